hci_datamover_core: RTL and testbench
=====================================

// Module: hci_datamover_core
// PURPOSE
//  Word-granular TCDM copy engine; one instance drives each core initiator port (N_CORE)
//  and the HWPE port (N_HWPE, DW=DW_hwpe) upstream of the HCI/log interconnect.
//  Copies LEN words from SRC to DST via one req/gnt + r_valid TCDM master port.
//  Reads are buffered in a small data FIFO. Requests and responses are tracked in order.
// PARAMETERS
//  DW        32  data width (DW_cores; DW_hwpe for HWPE instance)
//  AW        32  address width
//  BW        8   byte width; BE width = DW/BW
//  LEN_W     16  width of length/counter fields
//  DEPTH     4   data FIFO depth = max reads in flight + buffered (power of 2, >=2)
// PORTS
//  clk_i           in   1       clock
//  rst_i           in   1       synchronous reset, active-high
//  start_i         in   1       launch copy (sampled in IDLE only)
//  src_addr_i      in   AW      byte source address (DW/8-aligned)
//  dst_addr_i      in   AW      byte destination address (DW/8-aligned)
//  len_i           in   LEN_W   number of DW-words to copy
//  busy_o          out  1       high from accepted start until done_o
//  done_o          out  1       1-cycle pulse at completion
//  tcdm_req_o      out  1       request valid
//  tcdm_gnt_i      in   1       grant
//  tcdm_add_o      out  AW      request byte address
//  tcdm_wen_o      out  1       1=read, 0=write
//  tcdm_be_o       out  DW/BW   byte enables, always all-ones
//  tcdm_data_o     out  DW      write data
//  tcdm_r_data_i   in   DW      read response data
//  tcdm_r_valid_i  in   1       response valid (reads AND writes), in grant order
//  checksum_o      out  DW      running checksum (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0 (tcdm_wen_o=0, tcdm_be_o='1). FSM=IDLE, counters, FIFOs and in-flight state cleared.
//  - FSM: IDLE -> RUN on start_i with len_i!=0; IDLE -> FINISH on start_i with len_i==0.
//    RUN -> DRAIN when the last write is granted. DRAIN -> FINISH when the outstanding-response count is 0.
//    FINISH -> IDLE after one cycle, with done_o=1 and busy_o=0 in that cycle.
//  - Latency: len_i==0 gives done_o 1 cycle after start_i, with no requests issued.
//  - busy_o=1 in RUN and DRAIN. start_i outside IDLE is ignored.
//  - Issue arbitration in RUN, evaluated when no request is pending or on the gnt cycle:
//    1) A write is issued if the data FIFO is non-empty: data = FIFO head, add = dst pointer.
//    2) Else a read is issued if reads remain and (reads in flight + FIFO count) < DEPTH: add = src pointer.
//    3) Else tcdm_req_o=0.
//  - Handshake: once tcdm_req_o=1, req/add/wen/data stay stable until the cycle tcdm_gnt_i=1.
//    On gnt, the next request may be presented in the following cycle (no bubble required).
//  - On gnt: the src or dst pointer advances by DW/8 and wraps modulo 2^AW. A type tag (R/W) is pushed into a DEPTH*2 tag FIFO.
//    The write's FIFO entry is popped on gnt.
//  - On tcdm_r_valid_i: the tag FIFO is popped.
//    A tag of R pushes tcdm_r_data_i into the data FIFO; a free slot is guaranteed by the credit rule.
//    A tag of W discards the data.
//  - r_valid may coincide with gnt (push and pop in the same cycle are legal on both FIFOs). It arrives >=1 cycle after its gnt.
//  - r_valid while the tag FIFO is empty (e.g. after reset mid-operation) is ignored.
//  - Reset mid-operation: req drops the same cycle reset is seen high. Late responses are ignored as above.
//  - Counters are LEN_W wide. len_i = 2^LEN_W-1 is legal.
// CONFIGURATION
//  DATAMOVER_CHECKSUM_EN defined:
//   - checksum_o clears on accepted start.
//   - checksum_o = checksum_o + data (mod 2^DW), summed over every write data word on its gnt.
//   - Value is final and stable when done_o pulses and is held until the next start.
//  DATAMOVER_CHECKSUM_EN undefined: checksum_o tied to 0 and no adder logic is instantiated.
// TESTING
//  T1 len=0, start -> done_o at cycle+1, tcdm_req_o never 1, busy_o stays 0.
//  T2 len=4, src=0x000, dst=0x100, 1-cycle memory model with gnt always high:
//     -> 4 reads at 0x000..0x00C and 4 writes at 0x100..0x10C, dst words equal src words, a single done_o pulse.
//  T3 gnt held low for 5 cycles on the first read -> req/add/wen stable for all 5 cycles, no duplicate request.
//  T4 memory r_valid latency 3, len=16, DEPTH=4 -> reads in flight + buffered never exceed 4, all 16 words correct.
//  T5 rst_i asserted mid-copy at word 7, then stale r_valid x2 -> outputs at reset values, no FIFO push.
//     A subsequent len=2 copy completes correctly.
//  T6 (CHECKSUM_EN) copy words 1,2,3,0xFFFFFFFF -> checksum_o=0x00000005 at done_o.
//     With the macro undefined, checksum_o=0.

Source files
------------

// File: rtl/hci_datamover_core.sv
// hci_datamover_core: word-granular TCDM copy engine, LEN words from SRC to DST over one req/gnt + r_valid master port.
// Latency: len=0 -> done_o one cycle after start_i; otherwise one read plus one write handshake per word, pipelined.
// Backpressure: a request stays frozen until gnt; reads stop while (reads in flight + buffered words) reaches DEPTH.
// Ports: start_i/src_addr_i/dst_addr_i/len_i launch a copy; busy_o/done_o report progress;
//        tcdm_* is the TCDM master (request side plus in-order response side); checksum_o is the running write sum.
// Optional feature: define DATAMOVER_CHECKSUM_EN to sum every granted write word into checksum_o (else tied to 0).
module hci_datamover_core #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int BW    = 8,
  parameter int LEN_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [AW-1:0]    src_addr_i,
  input  logic [AW-1:0]    dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             tcdm_req_o,
  input  logic             tcdm_gnt_i,
  output logic [AW-1:0]    tcdm_add_o,
  output logic             tcdm_wen_o,
  output logic [DW/BW-1:0] tcdm_be_o,
  output logic [DW-1:0]    tcdm_data_o,
  input  logic [DW-1:0]    tcdm_r_data_i,
  input  logic             tcdm_r_valid_i,
  output logic [DW-1:0]    checksum_o
);
  localparam int DPW = $clog2(DEPTH);
  localparam int TPW = $clog2(DEPTH * 2);
  localparam int CW  = DPW + 1;
  localparam int TCW = TPW + 1;
  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
  state_t state_q, state_d;

  logic [AW-1:0]    src_q, dst_q;
  logic [LEN_W-1:0] rd_left_q, wr_left_q;
  logic [CW-1:0]    rif_q;                // reads granted, response not yet returned

  // frozen copy of a request that was presented but not yet granted
  logic             pend_q;
  logic [AW-1:0]    hold_add_q;
  logic             hold_wen_q;
  logic [DW-1:0]    hold_dat_q;

  // read-data FIFO and in-order response tag FIFO (tag 1 = read, 0 = write)
  logic [DW-1:0]    dmem [DEPTH];
  logic [DPW-1:0]   d_wp, d_rp;
  logic [CW-1:0]    d_cnt;
  logic             tmem [DEPTH*2];
  logic [TPW-1:0]   t_wp, t_rp;
  logic [TCW-1:0]   t_cnt;

  logic             req_c, wen_c;
  logic [AW-1:0]    add_c;
  logic [DW-1:0]    dat_c;
  logic [CW:0]      credit_used;
  logic             can_issue, issue_wr, issue_rd;
  logic             gnt_fire, wr_fire, rd_fire, tag_pop, resp_rd, start_ok;

  // Writes win so the buffer drains first; a read also needs a free data slot for its response.
  assign credit_used = {1'b0, rif_q} + {1'b0, d_cnt};
  assign can_issue   = (state_q == RUN) && (t_cnt != TCW'(DEPTH * 2));
  assign issue_wr    = can_issue && (d_cnt != '0);
  assign issue_rd    = can_issue && !issue_wr && (rd_left_q != '0) && (credit_used < (CW+1)'(DEPTH));

  always_comb begin
    req_c = 1'b0;
    wen_c = 1'b0;
    add_c = '0;
    dat_c = '0;
    if (pend_q) begin
      req_c = 1'b1;
      wen_c = hold_wen_q;
      add_c = hold_add_q;
      dat_c = hold_dat_q;
    end else if (issue_wr) begin
      req_c = 1'b1;
      add_c = dst_q;
      dat_c = dmem[d_rp];
    end else if (issue_rd) begin
      req_c = 1'b1;
      wen_c = 1'b1;
      add_c = src_q;
    end
  end

  // Request is cut combinationally so it drops in the very cycle reset is raised.
  assign tcdm_req_o  = req_c & ~rst_i;
  assign tcdm_wen_o  = wen_c;
  assign tcdm_add_o  = add_c;
  assign tcdm_data_o = dat_c;
  assign tcdm_be_o   = '1;

  assign gnt_fire = tcdm_req_o & tcdm_gnt_i;
  assign wr_fire  = gnt_fire & ~wen_c;
  assign rd_fire  = gnt_fire & wen_c;
  assign tag_pop  = tcdm_r_valid_i & (t_cnt != '0);   // responses with no outstanding tag are stale
  assign resp_rd  = tag_pop & tmem[t_rp];
  assign start_ok = (state_q == IDLE) & start_i;

  assign busy_o = (state_q == RUN) || (state_q == DRAIN);
  assign done_o = (state_q == FINISH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (len_i != '0) ? RUN : FINISH;
      RUN:     if (wr_fire && (wr_left_q == LEN_W'(1))) state_d = DRAIN;
      DRAIN:   if (t_cnt == '0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (resp_rd)  dmem[d_wp] <= tcdm_r_data_i;
    if (gnt_fire) tmem[t_wp] <= wen_c;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rd_left_q  <= '0;
      wr_left_q  <= '0;
      rif_q      <= '0;
      pend_q     <= 1'b0;
      hold_add_q <= '0;
      hold_wen_q <= 1'b0;
      hold_dat_q <= '0;
      d_wp       <= '0;
      d_rp       <= '0;
      d_cnt      <= '0;
      t_wp       <= '0;
      t_rp       <= '0;
      t_cnt      <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        src_q     <= src_addr_i;
        dst_q     <= dst_addr_i;
        rd_left_q <= len_i;
        wr_left_q <= len_i;
      end
      if (rd_fire) begin
        src_q     <= src_q + STEP;
        rd_left_q <= rd_left_q - LEN_W'(1);
      end
      if (wr_fire) begin
        dst_q     <= dst_q + STEP;
        wr_left_q <= wr_left_q - LEN_W'(1);
      end
      pend_q <= req_c & ~tcdm_gnt_i;
      if (!pend_q) begin
        hold_add_q <= add_c;
        hold_wen_q <= wen_c;
        hold_dat_q <= dat_c;
      end
      case ({rd_fire, resp_rd})
        2'b10:   rif_q <= rif_q + CW'(1);
        2'b01:   rif_q <= rif_q - CW'(1);
        default: ;
      endcase
      if (resp_rd) d_wp <= d_wp + DPW'(1);
      if (wr_fire) d_rp <= d_rp + DPW'(1);
      case ({resp_rd, wr_fire})
        2'b10:   d_cnt <= d_cnt + CW'(1);
        2'b01:   d_cnt <= d_cnt - CW'(1);
        default: ;
      endcase
      if (gnt_fire) t_wp <= t_wp + TPW'(1);
      if (tag_pop)  t_rp <= t_rp + TPW'(1);
      case ({gnt_fire, tag_pop})
        2'b10:   t_cnt <= t_cnt + TCW'(1);
        2'b01:   t_cnt <= t_cnt - TCW'(1);
        default: ;
      endcase
    end
  end

`ifdef DATAMOVER_CHECKSUM_EN
  logic [DW-1:0] csum_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)         csum_q <= '0;
    else if (start_ok) csum_q <= '0;
    else if (wr_fire)  csum_q <= csum_q + tcdm_data_o;
  end
  assign checksum_o = csum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_hci_datamover_core.sv
// Randomized bench for hci_datamover_core: a TCDM memory model with configurable grant/latency,
// a scoreboard of expected read addresses, write address/data pairs and completions, and a monitor.
module tb_hci_datamover_core;
  localparam int DEPTH = 4;
`ifdef DATAMOVER_CHECKSUM_EN
  localparam logic [31:0] CS_T6 = 32'h0000_0005;
`else
  localparam logic [31:0] CS_T6 = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, req, wen;
  logic        gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] add, wdata, checksum;
  logic [31:0] rdata = '0;
  logic [3:0]  be;

  hci_datamover_core dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .src_addr_i(src_addr), .dst_addr_i(dst_addr), .len_i(len),
    .busy_o(busy), .done_o(done),
    .tcdm_req_o(req), .tcdm_gnt_i(gnt), .tcdm_add_o(add), .tcdm_wen_o(wen),
    .tcdm_be_o(be), .tcdm_data_o(wdata), .tcdm_r_data_i(rdata), .tcdm_r_valid_i(rvalid),
    .checksum_o(checksum)
  );

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { int unsigned due; logic [31:0] d; } rsp_t;
  typedef struct { logic [31:0] cs; int unsigned start_cyc; bit zero_len; } done_t;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_rd [$];
  wr_t         exp_wr [$];
  done_t       exp_done [$];
  rsp_t        rsp_q [$];
  logic [31:0] words [$];

  int total = 0, bad = 0;
  int unsigned cyc = 0, last_due = 0;
  bit rand_gnt = 1'b0;
  int lat_min = 1, lat_max = 1;
  int hold_cnt = 0, stale_cnt = 0, stall_cnt = 0;
  int rd_g = 0, wr_g = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen 1 times, required 0", name);
  endtask

  task automatic flush();
    exp_rd.delete();
    exp_wr.delete();
    exp_done.delete();
    rsp_q.delete();
  endtask

  // Memory model: grants per rand_gnt/hold_cnt, answers every grant in order after lat_min..lat_max cycles.
  initial begin
    rsp_t r;
    rsp_t tmp;
    int unsigned due;
    forever begin
      @(negedge clk);
      if (stale_cnt > 0) begin
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; stale_cnt--;
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        rvalid = 1'b1; rdata = rsp_q[0].d; tmp = rsp_q.pop_front();
      end else begin
        rvalid = 1'b0; rdata = $urandom;
      end
      if (hold_cnt > 0 && req) begin
        gnt = 1'b0; hold_cnt--;
      end else if (rand_gnt) gnt = ($urandom_range(0, 2) != 0);
      else gnt = 1'b1;
      if (req && gnt) begin
        due = cyc + $urandom_range(lat_min, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        if (wen) r.d = mem.exists(add) ? mem[add] : 32'h0;
        else begin mem[add] = wdata; r.d = $urandom; end
        r.due = due;
        rsp_q.push_back(r);
      end
    end
  end

  // Monitor: protocol stability, scoreboard pops on grants, completion checks.
  initial begin
    bit pend_prev;
    logic [31:0] padd, pdat;
    logic pwen;
    done_t e;
    wr_t w;
    pend_prev = 1'b0; padd = '0; pdat = '0; pwen = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst) pend_prev = 1'b0;
      else begin
        if (pend_prev) begin
          chk("hold_req", {31'b0, req}, 32'd1);
          chk("hold_add", add, padd);
          chk("hold_wen", {31'b0, wen}, {31'b0, pwen});
          chk("hold_dat", wdata, pdat);
        end
        if (req && !gnt) stall_cnt++;
        if (req && gnt) begin
          if (wen) begin
            if (exp_rd.size() == 0) note_fail("unexpected_read");
            else begin
              chk("rd_addr", add, exp_rd.pop_front());
              rd_g++;
              chk("credit_limit", {31'b0, (rd_g - wr_g) <= DEPTH}, 32'd1);
            end
          end else begin
            if (exp_wr.size() == 0) note_fail("unexpected_write");
            else begin
              w = exp_wr.pop_front();
              chk("wr_addr", add, w.a);
              chk("wr_data", wdata, w.d);
              wr_g++;
            end
          end
        end
        if (done) begin
          chk("done_busy", {31'b0, busy}, 32'd0);
          if (exp_done.size() == 0) note_fail("unexpected_done");
          else begin
            e = exp_done.pop_front();
            chk("checksum", checksum, e.cs);
            chk("writes_left", 32'(exp_wr.size()), 32'd0);
            if (e.zero_len) chk("len0_latency", cyc, e.start_cyc + 1);
          end
        end
        pend_prev = req && !gnt;
        padd = add; pdat = wdata; pwen = wen;
      end
    end
  end

  // Loads source words into memory, queues expectations, pulses start (caller sits at posedge+2).
  task automatic launch(input logic [31:0] s, input logic [31:0] d, input int n, input bit use_words);
    logic [31:0] cs;
    logic [31:0] wv;
    done_t e;
    cs = '0;
    rd_g = 0; wr_g = 0;
    for (int i = 0; i < n; i++) begin
      wv = use_words ? words[i] : $urandom;
      mem[s + 32'(4 * i)] = wv;
      exp_rd.push_back(s + 32'(4 * i));
      exp_wr.push_back('{a: d + 32'(4 * i), d: wv});
      cs = cs + wv;
    end
`ifndef DATAMOVER_CHECKSUM_EN
    cs = '0;
`endif
    e.cs = cs; e.zero_len = (n == 0); e.start_cyc = cyc;
    exp_done.push_back(e);
    src_addr = s; dst_addr = d; len = 16'(n); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, {31'b0, n != 0});
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (exp_done.size() != 0 && k < limit) begin @(posedge clk); #2; k++; end
    if (exp_done.size() != 0) begin note_fail("done_timeout"); flush(); end
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #2; rst = 1'b0;
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_wen", {31'b0, wen}, 32'd0);
    chk("rst_be", {28'b0, be}, 32'hF);
    chk("rst_add", add, 32'd0);
    chk("rst_data", wdata, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_checksum", checksum, 32'd0);

    // zero-length copy
    launch(32'h0, 32'h100, 0, 1'b0);
    wait_done(10);

    // 4 words, grant always high, 1-cycle memory
    launch(32'h0, 32'h100, 4, 1'b0);
    wait_done(100);
    for (int i = 0; i < 4; i++) chk("t2_mem_copy", mem[32'h100 + 32'(4 * i)], mem[32'(4 * i)]);

    // first read stalled 5 cycles
    stall_cnt = 0; hold_cnt = 5;
    launch(32'h200, 32'h300, 4, 1'b0);
    wait_done(100);
    chk("t3_stall_cycles", 32'(stall_cnt), 32'd5);

    // latency 3, 16 words, credit bound watched on every read grant
    lat_min = 3; lat_max = 3;
    launch(32'h400, 32'h800, 16, 1'b0);
    wait_done(300);

    // address wrap at 2^32
    launch(32'hFFFF_FFF8, 32'h1000, 4, 1'b0);
    wait_done(100);

    // checksum pattern with wrap-around sum
    words.delete();
    words.push_back(32'd1); words.push_back(32'd2); words.push_back(32'd3); words.push_back(32'hFFFF_FFFF);
    launch(32'h40, 32'h80, 4, 1'b1);
    wait_done(100);
    repeat (3) begin @(posedge clk); #2; end
    chk("t6_checksum_hold", checksum, CS_T6);

    // reset in the middle of a copy, then stale responses
    launch(32'h2000, 32'h3000, 16, 1'b0);
    k = 0;
    while (wr_g < 7 && k < 300) begin @(posedge clk); #2; k++; end
    if (wr_g < 7) note_fail("t5_progress_timeout");
    rst = 1'b1;
    flush();
    #1;
    chk("t5_req_drop", {31'b0, req}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; stale_cnt = 2;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_done", {31'b0, done}, 32'd0);
    chk("t5_add", add, 32'd0);
    chk("t5_checksum", checksum, 32'd0);
    repeat (4) begin @(posedge clk); #2; end
    chk("t5_idle_req", {31'b0, req}, 32'd0);
    chk("t5_idle_busy", {31'b0, busy}, 32'd0);
    launch(32'h2400, 32'h2600, 2, 1'b0);
    wait_done(100);

    // randomized grants, latencies and lengths
    rand_gnt = 1'b1; lat_min = 1; lat_max = 4;
    for (int t = 0; t < 6; t++) begin
      launch(32'h1_0000 + 32'(t * 32'h1000), 32'h8_0000 + 32'(t * 32'h1000),
             int'($urandom_range(1, 24)), 1'b0);
      wait_done(600);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
